// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM state encoding and default bit timing.
package uart_rx_pkg;

  // Default clocks per bit, i.e. f_clk / baud.
  localparam int unsigned DefaultClksPerBit = 87;

  // Number of data bits in an 8N1 frame.
  localparam int unsigned DataBits = 8;

  // Receiver FSM states (3-bit encoding shared with the transmitter).
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStart   = 3'd1,
    StData    = 3'd2,
    StStop    = 3'd3,
    StCleanup = 3'd4,
    StBreak   = 3'd5
  } rx_state_e;

  // Mid-bit sample offset measured from the start-bit detect.
  function automatic int unsigned half_bit(input int unsigned clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  // Two-stage capture; both stages come out of reset at 1 so no false start bit is seen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, validates the start bit at mid-bit, samples each
// data bit once at mid-bit, and pulses o_Rx_DV (good stop) or o_Rx_Frame_Err (stop low).
// CLKS_PER_BIT must be at least 4.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam int unsigned HALF_BIT = half_bit(CLKS_PER_BIT);
  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0] CntHalf = CntW'(HALF_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic rx_s;

  rx_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic [7:0] byte_q, byte_d;
  logic dv_q, dv_d;
  logic ferr_q, ferr_d;
  logic active_q, active_d;

  uart_rx_sync u_sync (
    .clk_i (i_Clock),
    .rst_i (i_Reset),
    .d_i   (i_Rx_Serial),
    .q_o   (rx_s)
  );

  // Next-state, counters, shift register and registered output pulses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
    active_d = active_q;

    unique case (state_q)
      StIdle: begin
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
        if (!rx_s) begin
          state_d  = StStart;
          active_d = 1'b1;
        end
      end

      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = StData;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            state_d  = StIdle;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d         = '0;
          data_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = data_q;
            dv_d    = 1'b1;
            state_d = StCleanup;
          end else begin
            ferr_d   = 1'b1;
            active_d = 1'b0;
            state_d  = StBreak;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StCleanup: begin
        active_d = 1'b0;
        state_d  = StIdle;
      end

      StBreak: begin
        // Wait for the line to go idle so a held-low line cannot start a new frame.
        active_d = 1'b0;
        cnt_d    = '0;
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        active_d = 1'b0;
        cnt_d    = '0;
        idx_d    = '0;
        state_d  = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight without pulses.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
      active_q <= active_d;
    end
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = ferr_q;
  assign o_Rx_Active    = active_q;

endmodule
